// File: rtl/mux_arbiter2.sv
// Purpose : two-requester round-robin arbiter driving the select line of a shared 2:1 mux.
// Latency : a request sampled at edge N is granted after edge N (one cycle).
// Backpressure: none; requests are level-held, and each ownership is capped at MAX_HOLD cycles while the other side waits.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset
//   req0/1   - level requests from requester 0 / 1
//   gnt0/1   - registered grants (one-hot or zero)
//   sel      - registered mux select (0 = in0, 1 = in1); holds its value while idle
//   busy     - gnt0 | gnt1
//   hold_cnt - cycles the current owner has held the path (1 on the first granted cycle, 0 when idle)
module mux_arbiter2 #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          sel,
  output logic          busy,
  output logic [CW-1:0] hold_cnt
);

  // One-hot-or-idle encoding: each grant is a state flop, no decode logic.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_ONE = CW'(1);

  state_t state;
  logic   last;  // last requester served; the other one wins a tie from IDLE

  assign gnt0 = state[0];
  assign gnt1 = state[1];
  assign busy = state[0] | state[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      hold_cnt <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // Requester 0 wins when alone, or on a tie when requester 1 was served last.
          if (req0 && (!req1 || last)) begin
            state    <= OWN0;
            sel      <= 1'b0;
            hold_cnt <= HOLD_ONE;
            last     <= 1'b0;
          end else if (req1) begin
            state    <= OWN1;
            sel      <= 1'b1;
            hold_cnt <= HOLD_ONE;
            last     <= 1'b1;
          end
        end

        OWN0: begin
          if (req1 && (!req0 || hold_cnt == HOLD_MAX)) begin
            // Voluntary release or hold limit reached: hand over with no idle bubble.
            state    <= OWN1;
            sel      <= 1'b1;
            hold_cnt <= HOLD_ONE;
            last     <= 1'b1;
          end else if (!req0) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
          // Sole requester at the limit: counter saturates until req1 shows up.
        end

        OWN1: begin
          if (req0 && (!req1 || hold_cnt == HOLD_MAX)) begin
            state    <= OWN0;
            sel      <= 1'b0;
            hold_cnt <= HOLD_ONE;
            last     <= 1'b0;
          end else if (!req1) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end

        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter2.sv
module tb_mux_arbiter2;

  localparam int MAX_HOLD = 4;
  localparam int CW       = 3;

  logic          clk;
  logic          rst_n;
  logic          req0;
  logic          req1;
  logic          gnt0;
  logic          gnt1;
  logic          sel;
  logic          busy;
  logic [CW-1:0] hold_cnt;

  int total;
  int bad;

  // Reference model: owner is -1 (nobody), 0 or 1.
  int m_owner;
  int m_cnt;
  int m_last;
  int m_sel;

  mux_arbiter2 #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_grant(input int who);
    m_owner = who;
    m_cnt   = 1;
    m_last  = who;
    m_sel   = who;
  endfunction

  function automatic void model_step(input logic r, input logic a, input logic b);
    int want[2];
    int o;
    want[0] = int'(a);
    want[1] = int'(b);
    if (!r) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 1;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      if (want[0] != 0 && want[1] != 0) model_grant(1 - m_last);
      else if (want[0] != 0)            model_grant(0);
      else if (want[1] != 0)            model_grant(1);
    end else begin
      o = m_owner;
      if (want[o] == 0) begin
        if (want[1-o] != 0) model_grant(1 - o);
        else begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end else if (want[1-o] != 0 && m_cnt == MAX_HOLD) begin
        model_grant(1 - o);
      end else if (m_cnt < MAX_HOLD) begin
        m_cnt = m_cnt + 1;
      end
    end
  endfunction

  // Advance one clock, step the model with the values the DUT sampled, settle away from the edge.
  task automatic tick();
    @(posedge clk);
    model_step(rst_n, req0, req1);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    tick();
    total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1}); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL reset_sel: got %b want 0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (hold_cnt !== 3'd0) begin bad++; $display("FAIL reset_hold: got %0d want 0", hold_cnt); end
    rst_n = 1'b1;
    tick();
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0 || hold_cnt !== 3'd1) begin
      bad++; $display("FAIL reset_release: got gnt0=%b gnt1=%b sel=%b hold=%0d want 1 0 0 1", gnt0, gnt1, sel, hold_cnt);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || sel !== 1'b1 || int'(hold_cnt) != (i < MAX_HOLD ? i : MAX_HOLD)) begin
        bad++; $display("FAIL single_c%0d: got gnt1=%b sel=%b hold=%0d want 1 1 %0d", i, gnt1, sel, hold_cnt, (i < MAX_HOLD ? i : MAX_HOLD));
      end
    end
    req1 = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || sel !== 1'b1 || hold_cnt !== 3'd0) begin
      bad++; $display("FAIL single_drop: got busy=%b sel=%b hold=%0d want 0 1 0", busy, sel, hold_cnt);
    end
    // Saturate, then let the other side arrive.
    req1 = 1'b1;
    repeat (6) tick();
    req0 = 1'b1;
    tick();
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0 || hold_cnt !== 3'd1) begin
      bad++; $display("FAIL saturated_switch: got gnt0=%b gnt1=%b sel=%b hold=%0d want 1 0 0 1", gnt0, gnt1, sel, hold_cnt);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int exp_owner;
    // last served is 0 here, so the tie from idle goes to requester 1 first.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_owner = ((i / MAX_HOLD) % 2 == 0) ? 1 : 0;
      total++; if (gnt0 !== (exp_owner == 0) || gnt1 !== (exp_owner == 1) || busy !== 1'b1 || int'(hold_cnt) != (i % MAX_HOLD) + 1) begin
        bad++; $display("FAIL contention_c%0d: got gnt0=%b gnt1=%b busy=%b hold=%0d want owner %0d hold %0d", i, gnt0, gnt1, busy, hold_cnt, exp_owner, (i % MAX_HOLD) + 1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_handover();
    req0 = 1'b1;
    tick();
    tick();
    total++; if (gnt0 !== 1'b1 || hold_cnt !== 3'd2) begin bad++; $display("FAIL handover_pre: got gnt0=%b hold=%0d want 1 2", gnt0, hold_cnt); end
    req0 = 1'b0; req1 = 1'b1;
    tick();
    total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || sel !== 1'b1 || hold_cnt !== 3'd1) begin
      bad++; $display("FAIL handover: got gnt0=%b gnt1=%b sel=%b hold=%0d want 0 1 1 1", gnt0, gnt1, sel, hold_cnt);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_tie_after_idle();
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (busy !== 1'b0 || hold_cnt !== 3'd0) begin bad++; $display("FAIL tie_idle_c%0d: got busy=%b hold=%0d want 0 0", i, busy, hold_cnt); end
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin bad++; $display("FAIL tie_after_idle: got gnt0=%b gnt1=%b want 0 1", gnt0, gnt1); end
  endtask

  task automatic test_reset_mid();
    // Continues from OWN1 at hold 1 with both requesting.
    tick();
    tick();
    total++; if (gnt1 !== 1'b1 || hold_cnt !== 3'd3) begin bad++; $display("FAIL midrst_pre: got gnt1=%b hold=%0d want 1 3", gnt1, hold_cnt); end
    rst_n = 1'b0;
    tick();
    total++; if ({gnt0, gnt1, sel, busy} !== 4'b0000 || hold_cnt !== 3'd0) begin
      bad++; $display("FAIL midrst: got gnt0=%b gnt1=%b sel=%b busy=%b hold=%0d want all 0", gnt0, gnt1, sel, busy, hold_cnt);
    end
    rst_n = 1'b1;
    tick();
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL midrst_release: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      // Bias requests high so contention and saturation occur often.
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (gnt0 !== (m_owner == 0) || gnt1 !== (m_owner == 1) || busy !== (m_owner >= 0) ||
                   sel !== m_sel[0] || int'(hold_cnt) != m_cnt) begin
        bad++; $display("FAIL random_c%0d: got gnt0=%b gnt1=%b busy=%b sel=%b hold=%0d want owner %0d sel %0d hold %0d",
                        i, gnt0, gnt1, busy, sel, hold_cnt, m_owner, m_sel, m_cnt);
      end
      total++; if ((gnt0 & gnt1) !== 1'b0 || (busy && sel !== gnt1) || int'(hold_cnt) > MAX_HOLD) begin
        bad++; $display("FAIL random_inv_c%0d: got gnt0=%b gnt1=%b sel=%b hold=%0d", i, gnt0, gnt1, sel, hold_cnt);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    m_owner = -1; m_cnt = 0; m_last = 1; m_sel = 0;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_handover();
    test_tie_after_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
